// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared types for the instruction fetch stage.
//               - word_t        : 32-bit machine word (pc and instruction)
//               - base_opcode_t : RV32 base opcodes (instr[6:0])
//               - fetch_entry_t : one queue entry {pc, instr[, is_control]}
//               - is_control_op : predecode helper (branch/jal/jalr/system)
//               - asm_*         : tiny assemblers used to build bench stimulus
//               Optional macro FETCH_PREDECODE_EN adds is_control to entries.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [6:0] {
        OPCODE_LOAD   = 7'b0000011,
        OPCODE_OP_IMM = 7'b0010011,
        OPCODE_AUIPC  = 7'b0010111,
        OPCODE_STORE  = 7'b0100011,
        OPCODE_OP     = 7'b0110011,
        OPCODE_LUI    = 7'b0110111,
        OPCODE_BRANCH = 7'b1100011,
        OPCODE_JALR   = 7'b1100111,
        OPCODE_JAL    = 7'b1101111,
        OPCODE_SYSTEM = 7'b1110011
    } base_opcode_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
`ifdef FETCH_PREDECODE_EN
        logic  is_control;
`endif
    } fetch_entry_t;

    // True for opcodes that can change control flow.
    function automatic logic is_control_op(input logic [6:0] opcode);
        case (opcode)
            OPCODE_BRANCH, OPCODE_JAL, OPCODE_JALR, OPCODE_SYSTEM: return 1'b1;
            default:                                               return 1'b0;
        endcase
    endfunction

    // addi rd, rs1, imm
    function automatic word_t asm_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, OPCODE_OP_IMM};
    endfunction

    // add rd, rs1, rs2
    function automatic word_t asm_add(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, 3'b000, rd, OPCODE_OP};
    endfunction

    // beq rs1, rs2, offset ; imm_12_1 holds byte-offset bits [12:1]
    // (bit 0 of a branch offset is always zero).
    function automatic word_t asm_beq(input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [12:1] imm_12_1);
        return {imm_12_1[12], imm_12_1[10:5], rs2, rs1, 3'b000,
                imm_12_1[4:1], imm_12_1[11], OPCODE_BRANCH};
    endfunction

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit_instruction_queue.sv
`default_nettype none
// ============================================================================
// Module      : instruction_queue
// Description : Parametric FIFO of fetch_entry_t feeding the decoder.
//               Flush has priority over push and pop; the head is read
//               combinationally, so a pop coinciding with a flush still
//               hands the current head to the consumer.
// Ports       : clk, reset (async, active-low)
//               i_push/i_entry : write one entry
//               i_pop          : consume head (ignored when empty)
//               i_flush        : empty the queue
//               o_head         : head entry
//               o_count        : number of valid entries
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  fetch_entry_t             i_entry,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output fetch_entry_t             o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W + 1)'(DEPTH);

    fetch_entry_t         r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W:0]     r_count;

    logic                 w_do_push;
    logic                 w_do_pop;

    assign w_do_push = i_push & ~i_flush;
    assign w_do_pop  = i_pop & ~i_flush & (r_count != '0);

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // The producer only requests while there is room, so a push into a full
    // queue means the fetch side lost track of occupancy.
    a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
                                     !(w_do_push && (r_count == c_FULL)));

endmodule : instruction_queue
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Issues word reads on the instruction
//               bus, buffers {pc, instr} in instruction_queue and presents the
//               head to decode over valid/ready. Redirects flush the queue;
//               a request left pending by a redirect is completed in DISCARD
//               and its data dropped.
//               Optional macro FETCH_PREDECODE_EN adds out_is_control.
// Ports       : clk, reset (async, active-low)
//               redirect_valid/redirect_pc        : restart fetch
//               mem_valid/mem_address/mem_ready/mem_rdata : instruction bus
//               out_valid/out_ready/out_pc/out_instr      : decode handshake
//               out_is_control (FETCH_PREDECODE_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter word_t RESET_PC    = 32'h0000_0000,
    parameter int    QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_valid,
    output logic [31:0] mem_address,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
`ifdef FETCH_PREDECODE_EN
    ,
    output logic        out_is_control
`endif
);

    localparam int                c_CNT_W    = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(QUEUE_DEPTH);
    localparam word_t             c_RESET_PC = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    fetch_state_t          r_state;
    word_t                 r_fetch_pc;
    word_t                 r_orphan_addr;

    word_t                 w_redirect_pc;
    logic [1:0]            w_unused_redirect_lsbs;
    logic [c_CNT_W-1:0]    w_count;
    logic                  w_push;
    logic                  w_pop;
    fetch_entry_t          w_push_entry;
    fetch_entry_t          w_head;

    assign w_redirect_pc          = {redirect_pc[31:2], 2'b00};
    assign w_unused_redirect_lsbs = redirect_pc[1:0];

    // Bus request depends only on registered state. Occupancy can only grow
    // through an accepted request, so a raised request cannot drop before
    // mem_ready.
    assign mem_valid   = (r_state == DISCARD) ||
                         ((r_state == FETCH) && (w_count < c_FULL));
    assign mem_address = (r_state == DISCARD) ? r_orphan_addr : r_fetch_pc;

    // -------------------------------------------------------------------------
    // Fetch control
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_fetch_pc    <= c_RESET_PC;
            r_orphan_addr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                    if (redirect_valid) begin
                        r_fetch_pc <= w_redirect_pc;
                    end
                end
                FETCH: begin
                    if (redirect_valid) begin
                        r_fetch_pc <= w_redirect_pc;
                        // A request already on the bus must be held until
                        // accepted; its data belongs to the old stream.
                        if (mem_valid && !mem_ready) begin
                            r_orphan_addr <= r_fetch_pc;
                            r_state       <= DISCARD;
                        end
                    end else if (mem_valid && mem_ready) begin
                        r_fetch_pc <= r_fetch_pc + 32'd4;
                    end
                end
                DISCARD: begin
                    if (redirect_valid) begin
                        r_fetch_pc <= w_redirect_pc;
                    end
                    // Once the orphan is answered there is nothing left to
                    // wait for, even if a new redirect arrives in that cycle.
                    if (mem_ready) begin
                        r_state <= FETCH;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Queue interface
    // -------------------------------------------------------------------------
    assign w_push = (r_state == FETCH) && mem_valid && mem_ready && !redirect_valid;
    assign w_pop  = out_valid && out_ready;

    always_comb begin
        w_push_entry       = '0;
        w_push_entry.pc    = r_fetch_pc;
        w_push_entry.instr = mem_rdata;
`ifdef FETCH_PREDECODE_EN
        w_push_entry.is_control = is_control_op(mem_rdata[6:0]);
`endif
    end

    instruction_queue #(
        .DEPTH   (QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign out_valid = (w_count != '0);
    assign out_pc    = w_head.pc;
    assign out_instr = w_head.instr;
`ifdef FETCH_PREDECODE_EN
    assign out_is_control = out_valid & w_head.is_control;
`endif

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit. A combinational
//               memory model answers on mem_address; out_* is sampled 1 time
//               unit after each rising edge.
//               Optional macro FETCH_PREDECODE_EN enables predecode checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_valid;
    logic [31:0] mem_address;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
`ifdef FETCH_PREDECODE_EN
    logic        out_is_control;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_valid      (mem_valid),
        .mem_address    (mem_address),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
`ifdef FETCH_PREDECODE_EN
        ,
        .out_is_control (out_is_control)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return asm_addi(5'd1, 5'd0, 12'd5);
            32'h0000_0200: return asm_beq(5'd1, 5'd2, 12'd4);
            32'h0000_0204: return asm_add(5'd3, 5'd1, 5'd2);
            default:       return addr | 32'hABC0_0000;
        endcase
    endfunction

    assign mem_rdata = mem_word(mem_address);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] acc_addr [8];
    int          accepts;

    initial begin
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_ready      = 1'b1;
        out_ready      = 1'b1;
        #1;
        chk("rst_mem_valid",   32'(mem_valid), 32'd0);
        chk("rst_out_valid",   32'(out_valid), 32'd0);
        chk("rst_out_pc",      out_pc,         32'd0);
        chk("rst_out_instr",   out_instr,      32'd0);
        chk("rst_mem_address", mem_address,    32'd0);

        // ---- streaming after reset ----
        tick();
        reset = 1'b1;
        tick();                                   // edge 1: IDLE -> FETCH
        chk("e1_out_valid", 32'(out_valid), 32'd0);
        chk("e1_mem_valid", 32'(mem_valid), 32'd1);
        chk("e1_mem_addr",  mem_address,    32'd0);
        tick();                                   // edge 2: first word queued
        chk("e2_out_valid", 32'(out_valid), 32'd1);
        chk("e2_out_pc",    out_pc,         32'd0);
        chk("e2_out_instr", out_instr,      32'h0050_0093);
        tick();
        chk("s_pc4",    out_pc,    32'd4);
        chk("s_instr4", out_instr, 32'hABC0_0004);
        tick();
        chk("s_pc8",    out_pc,    32'd8);
        tick();
        chk("s_pc12",   out_pc,    32'd12);

        // ---- backpressure from reset ----
        reset     = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("bp_rst_out_valid", 32'(out_valid), 32'd0);
        reset   = 1'b1;
        accepts = 0;
        for (int i = 0; i < 6; i++) begin
            if (mem_valid && mem_ready && accepts < 8) begin
                acc_addr[accepts] = mem_address;
                accepts++;
            end
            tick();
        end
        chk("bp_accepts",   32'(accepts),   32'd2);
        chk("bp_acc0",      acc_addr[0],    32'd0);
        chk("bp_acc1",      acc_addr[1],    32'd4);
        chk("bp_mem_valid", 32'(mem_valid), 32'd0);
        chk("bp_out_pc",    out_pc,         32'd0);
        chk("bp_out_instr", out_instr,      32'h0050_0093);
        out_ready = 1'b1;
        tick();
        chk("bp_drain4",    out_pc,         32'd4);
        chk("bp_resume_va", 32'(mem_valid), 32'd1);
        chk("bp_resume_ad", mem_address,    32'd8);
        tick();
        chk("bp_drain8",    out_pc,         32'd8);

        // ---- redirect with PCs 8 and 12 queued ----
        out_ready = 1'b0;
        tick();
        chk("rd_pre_head",  out_pc,         32'd8);
        chk("rd_pre_full",  32'(mem_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        chk("rd_flushed",   32'(out_valid), 32'd0);
        chk("rd_new_addr",  mem_address,    32'h0000_0100);
        tick();
        chk("rd_valid",     32'(out_valid), 32'd1);
        chk("rd_pc",        out_pc,         32'h0000_0100);
        chk("rd_instr",     out_instr,      32'hABC0_0100);
        tick();
        chk("rd_pc_next",   out_pc,         32'h0000_0104);

        // ---- orphaned request ----
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0010;
        tick();                                   // accepted beat dropped
        redirect_valid = 1'b0;
        mem_ready      = 1'b0;
        chk("or_flushed",   32'(out_valid), 32'd0);
        chk("or_req_addr",  mem_address,    32'h0000_0010);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        tick();                                   // into DISCARD
        redirect_valid = 1'b0;
        chk("or_hold_va",   32'(mem_valid), 32'd1);
        chk("or_hold_ad1",  mem_address,    32'h0000_0010);
        tick();
        chk("or_hold_ad2",  mem_address,    32'h0000_0010);
        chk("or_no_out",    32'(out_valid), 32'd0);
        mem_ready = 1'b1;
        tick();                                   // orphan answered, data dropped
        chk("or_dropped",   32'(out_valid), 32'd0);
        chk("or_next_addr", mem_address,    32'h0000_0040);
        tick();
        chk("or_out_pc",    out_pc,         32'h0000_0040);
        chk("or_out_instr", out_instr,      32'hABC0_0040);

        // ---- address wrap ----
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        chk("wr_addr_top",  mem_address,    32'hFFFF_FFFC);
        tick();
        chk("wr_out_top",   out_pc,         32'hFFFF_FFFC);
        chk("wr_addr_zero", mem_address,    32'h0000_0000);
        tick();
        chk("wr_out_zero",  out_pc,         32'h0000_0000);
        chk("wr_instr0",    out_instr,      32'h0050_0093);

`ifdef FETCH_PREDECODE_EN
        // ---- predecode ----
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        chk("pd_idle",      32'(out_is_control), 32'd0);
        tick();
        chk("pd_beq_instr", out_instr,           32'h0020_8463);
        chk("pd_beq_ctl",   32'(out_is_control), 32'd1);
        tick();
        chk("pd_add_instr", out_instr,           32'h0020_81B3);
        chk("pd_add_ctl",   32'(out_is_control), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "tb_fetch_unit timeout");
    end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decoder.
- Issues word reads on the instruction bus and buffers returned words with their PC in a small queue.
- Presents {pc, instruction word} to decode over a valid/ready handshake.
- Handles redirects from branches, jumps, traps and mret by flushing the queue and discarding any in-flight response.

Parameters:
RESET_PC, 32'h00000000, fetch address after reset (bits [1:0] must be 0)
QUEUE_DEPTH, 2, instruction queue entries; power of two, >= 2

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
redirect_valid  input  1  flush queue and restart fetch at redirect_pc
redirect_pc  input  32  new fetch address; bits [1:0] forced to 0 internally
mem_valid  output  1  instruction bus request
mem_address  output  32  request address, word aligned
mem_ready  input  1  request accepted and mem_rdata valid in the same cycle
mem_rdata  input  32  fetched instruction word
out_valid  output  1  queue head valid to decoder
out_ready  input  1  decoder accepts head
out_pc  output  32  PC of head
out_instr  output  32  instruction word of head

Behaviour:
- Reset is asynchronous and active-low on `reset`. While asserted:
  - state=IDLE, fetch_pc=RESET_PC, queue count=0, pointers=0, entries=0.
  - Outputs: mem_valid=0, out_valid=0, out_pc=0, out_instr=0, mem_address=RESET_PC.
- States:
  - IDLE: first edge after reset release -> FETCH.
  - FETCH: normal operation.
  - DISCARD: waiting for an orphaned bus response.
- mem_valid = (state==DISCARD) or (state==FETCH and count<QUEUE_DEPTH). It depends only on registered state; there is no combinational path from out_ready.
- Bus rule: once mem_valid rises, mem_valid and mem_address stay stable until mem_ready=1.
- mem_address = fetch_pc in FETCH; the latched orphan address in DISCARD.
- FETCH with mem_ready=1:
  - push {fetch_pc, mem_rdata}.
  - fetch_pc <= fetch_pc+4, modulo 2^32; 32'hFFFFFFFC wraps to 0.
- Pop when out_valid and out_ready; the head advances next edge. Push and pop in the same cycle keep count unchanged.
- out_valid = count!=0. out_pc/out_instr come from the head entry and are stable while out_valid and not out_ready.
- Latency and throughput:
  - With mem_ready tied 1, out_valid rises after the 2nd edge following reset release.
  - Thereafter 1 instruction/cycle when out_ready=1.
- Redirect (redirect_valid=1) takes priority over everything else:
  - A pop handshake in the same cycle still counts as transferred.
  - All other entries are flushed: count=0 next cycle.
  - A push from mem_ready in the same cycle is dropped.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - If mem_valid=1 and mem_ready=0 at redirect: latch the current address, go to DISCARD, keep the request until mem_ready, drop its data, then go to FETCH. The next request uses the new pc.
  - Redirect while in DISCARD: update fetch_pc, remain in DISCARD.
- Queue pointers wrap modulo QUEUE_DEPTH. Overflow is impossible by construction; an assertion checks that no push occurs when count==QUEUE_DEPTH.

Optional Feature:
- Macro FETCH_PREDECODE_EN.
- When defined, add output out_is_control (1 bit), registered alongside each queue entry. It is 1 iff the entry's instr[6:0] is OPCODE_BRANCH, OPCODE_JAL, OPCODE_JALR or OPCODE_SYSTEM, and 0 when out_valid=0.
- When undefined, the port and its storage are absent; all other behaviour is identical.

Decomposition:
- Types_pkg: word_t is reused for the pc and instruction fields.
- Opcodes_pkg supplies:
  - base_opcode_t and the OPCODE_* constants used by predecode.
  - asm_* functions for bench stimulus.
  - New: typedef fetch_entry_t (pc, instr, optional is_control).
- fetch_state_t (IDLE, FETCH, DISCARD) stays local to the module.
- Sub-module instruction_queue: parametric FIFO of fetch_entry_t with push, pop, flush, count. Flush has priority over push; pop-with-flush returns the head.

Test Plan:
- Reset release, mem_ready=1, memory[0]=asm_addi(1,0,5), out_ready=1:
  - Edge 2 gives out_valid=1, out_pc=0, out_instr=32'h00500093.
  - Then out_pc=4, 8, 12 on consecutive cycles.
- Backpressure, out_ready=0 from start, QUEUE_DEPTH=2:
  - Exactly 2 bus accepts (addresses 0, 4), then mem_valid=0.
  - out_pc holds 0 and out_instr holds stable.
  - Raising out_ready drains 0, 4, then fetch resumes at 8.
- Redirect mid-stream, redirect_pc=32'h100 with queue holding PCs 8 and 12:
  - Next out_valid entry has out_pc=32'h100.
  - PCs 8 and 12 never appear after the redirect cycle.
- Orphan discard, mem_ready held 0 at address 16, redirect to 32'h40 (whose data is 0x40 | 0xABC00000):
  - mem_address stays 16 until mem_ready.
  - That data is never output.
  - The next request is 32'h40.
- Wrap-around, redirect_pc=32'hFFFFFFFE:
  - Fetch at 32'hFFFFFFFC, then 32'h00000000.
- FETCH_PREDECODE_EN defined, stream asm_beq(1,2,8), asm_add(3,1,2):
  - out_is_control = 1, then 0.
